// File: rtl/t5_pkg.sv
// rtl/t5_pkg.sv - shared constants and FSM states for the multi-hart register file
package t5_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REGW     = 5;

  typedef enum logic [1:0] {
    CLR_ALL  = 2'd0,
    RUN      = 2'd1,
    CLR_HART = 2'd2
  } state_t;

endpackage

// File: rtl/dpram.sv
// rtl/dpram.sv - simple dual-port RAM, one write port, one registered read port
module dpram #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  // Contents are deliberately unreset; the owner initialises them.
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/t5_mgprf.sv
// rtl/t5_mgprf.sv - per-hart register file with write bypass and hardware clear sweeps
module t5_mgprf
  import t5_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int HW   = 2
) (
  input  logic            sclk,
  input  logic            srst_n,
  input  logic [HW-1:0]   fhart,
  input  logic [4:0]      rs1a,
  input  logic [4:0]      rs2a,
  output logic [XLEN-1:0] rs1d,
  output logic [XLEN-1:0] rs2d,
  input  logic [HW-1:0]   mhart,
  input  logic [4:0]      rd0a,
  input  logic [XLEN-1:0] rd0d,
  input  logic            mwre,
  input  logic            hclr,
  input  logic [HW-1:0]   hclr_hart,
  output logic            busy
);

  localparam int AW = HW + REGW;
  localparam logic [AW-1:0]   CNT_LAST = '1;
  localparam logic [REGW-1:0] REG_LAST = '1;

  state_t        state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic [HW-1:0] clr_hart_q, clr_hart_nx;

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      state      <= CLR_ALL;
      cnt        <= '0;
      clr_hart_q <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      clr_hart_q <= clr_hart_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    clr_hart_nx = clr_hart_q;
    case (state)
      CLR_ALL: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == CNT_LAST) state_nx = RUN;
      end
      RUN: begin
        if (hclr) begin
          state_nx    = CLR_HART;
          clr_hart_nx = hclr_hart;
          cnt_nx      = '0;
        end
      end
      CLR_HART: begin
        if (cnt[REGW-1:0] == REG_LAST) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = CLR_ALL;
        cnt_nx   = '0;
      end
    endcase
  end

  assign busy = (state != RUN);

  // Register 0 is never stored, so it cannot be bypassed either.
  logic            user_we;
  logic            ram_we;
  logic [AW-1:0]   ram_waddr;
  logic [XLEN-1:0] ram_wdata;

  assign user_we   = mwre && !busy && (rd0a != '0);
  assign ram_we    = busy || user_we;
  assign ram_wdata = busy ? '0 : rd0d;

  always_comb begin
    ram_waddr = {mhart, rd0a};
    if (state == CLR_ALL)       ram_waddr = cnt;
    else if (state == CLR_HART) ram_waddr = {clr_hart_q, cnt[REGW-1:0]};
  end

  logic [1:0][REGW-1:0] rsa;
  logic [1:0][XLEN-1:0] ram_q;
  logic [1:0][XLEN-1:0] rsd;
  logic [1:0]           zero_q;
  logic [1:0]           byp_q;
  logic [XLEN-1:0]      byp_data;

  assign rsa = {rs2a, rs1a};

  // Reads issued while busy also return zero, hiding read-during-clear races.
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      zero_q   <= '1;
      byp_q    <= '0;
      byp_data <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        zero_q[p] <= busy || (rsa[p] == '0);
        byp_q[p]  <= user_we && ({mhart, rd0a} == {fhart, rsa[p]});
      end
      byp_data <= rd0d;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    dpram #(
      .AW(AW),
      .DW(XLEN)
    ) u_ram (
      .clk  (sclk),
      .we   (ram_we),
      .waddr(ram_waddr),
      .wdata(ram_wdata),
      .raddr({fhart, rsa[p]}),
      .rdata(ram_q[p])
    );

    assign rsd[p] = (busy || zero_q[p]) ? '0 :
                    byp_q[p]            ? byp_data : ram_q[p];
  end

  assign rs1d = rsd[0];
  assign rs2d = rsd[1];

endmodule

// File: tb/tb_t5_mgprf.sv
// tb/tb_t5_mgprf.sv - directed self-checking bench for t5_mgprf
module tb_t5_mgprf;

  logic        sclk = 1'b0;
  logic        srst_n;
  logic [1:0]  fhart, mhart, hclr_hart;
  logic [4:0]  rs1a, rs2a, rd0a;
  logic [31:0] rs1d, rs2d, rd0d;
  logic        mwre, hclr, busy;

  int tests = 0;
  int fails = 0;
  int n;

  t5_mgprf #(.XLEN(32), .HW(2)) dut (
    .sclk(sclk), .srst_n(srst_n), .fhart(fhart), .rs1a(rs1a), .rs2a(rs2a),
    .rs1d(rs1d), .rs2d(rs2d), .mhart(mhart), .rd0a(rd0a), .rd0d(rd0d),
    .mwre(mwre), .hclr(hclr), .hclr_hart(hclr_hart), .busy(busy)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] h, input logic [4:0] a, input logic [31:0] d);
    mhart = h; rd0a = a; rd0d = d; mwre = 1'b1;
    @(negedge sclk);
    mwre = 1'b0;
  endtask

  task automatic rd(input logic [1:0] h, input logic [4:0] a1, input logic [4:0] a2);
    fhart = h; rs1a = a1; rs2a = a2;
    @(negedge sclk);
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 1000) begin
      cnt++;
      @(negedge sclk);
    end
  endtask

  initial begin
    srst_n = 1'b0; fhart = '0; mhart = '0; hclr_hart = '0;
    rs1a = '0; rs2a = '0; rd0a = '0; rd0d = '0; mwre = 1'b0; hclr = 1'b0;
    repeat (3) @(negedge sclk);
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_rs1d", rs1d, 32'd0);
    chk("reset_rs2d", rs2d, 32'd0);

    srst_n = 1'b1;
    count_busy(n);
    chk("full_clear_len", n, 32'd128);

    rd(2'd0, 5'd1, 5'd31);
    chk("post_clear_h0r1", rs1d, 32'd0);
    chk("post_clear_h0r31", rs2d, 32'd0);
    rd(2'd3, 5'd17, 5'd30);
    chk("post_clear_h3r17", rs1d, 32'd0);
    chk("post_clear_h3r30", rs2d, 32'd0);

    wr(2'd1, 5'd5, 32'hDEADBEEF);
    rd(2'd1, 5'd5, 5'd5);
    chk("h1r5_rs1", rs1d, 32'hDEADBEEF);
    chk("h1r5_rs2_same", rs2d, 32'hDEADBEEF);
    rd(2'd2, 5'd5, 5'd0);
    chk("h2r5_zero", rs1d, 32'd0);

    wr(2'd0, 5'd0, 32'h12345678);
    rd(2'd0, 5'd0, 5'd0);
    chk("r0_rs1", rs1d, 32'd0);
    chk("r0_rs2", rs2d, 32'd0);

    mhart = 2'd3; rd0a = 5'd7; rd0d = 32'hA5A5A5A5; mwre = 1'b1;
    fhart = 2'd3; rs1a = 5'd0; rs2a = 5'd7;
    @(negedge sclk);
    mwre = 1'b0;
    chk("bypass_rs2", rs2d, 32'hA5A5A5A5);
    chk("bypass_rs1_r0", rs1d, 32'd0);
    @(negedge sclk);
    chk("stored_h3r7", rs2d, 32'hA5A5A5A5);

    for (int i = 1; i <= 4; i++) begin
      wr(2'd0, 5'(i), 32'h100 + 32'(i));
      wr(2'd2, 5'(i), 32'h200 + 32'(i));
    end
    rd(2'd2, 5'd3, 5'd4);
    chk("pre_hclr_h2r3", rs1d, 32'h203);

    hclr = 1'b1; hclr_hart = 2'd2;
    @(negedge sclk);
    hclr = 1'b0;
    n = 0;
    while (busy && n < 1000) begin
      if (n == 2) begin
        mhart = 2'd0; rd0a = 5'd10; rd0d = 32'h77; mwre = 1'b1;
        fhart = 2'd0; rs1a = 5'd1;
      end
      if (n == 3) begin
        mwre = 1'b0;
        chk("busy_read_zero", rs1d, 32'd0);
      end
      if (n == 5) begin hclr = 1'b1; hclr_hart = 2'd0; end
      if (n == 6) hclr = 1'b0;
      n++;
      @(negedge sclk);
    end
    chk("hart_clear_len", n, 32'd32);

    for (int i = 1; i <= 4; i++) begin
      rd(2'd2, 5'(i), 5'(i));
      chk($sformatf("h2r%0d_cleared", i), rs1d, 32'd0);
      rd(2'd0, 5'(i), 5'(i));
      chk($sformatf("h0r%0d_kept", i), rs2d, 32'h100 + 32'(i));
    end
    rd(2'd0, 5'd10, 5'd10);
    chk("busy_write_dropped", rs1d, 32'd0);

    mhart = 2'd1; rd0a = 5'd6; rd0d = 32'h55; mwre = 1'b1;
    hclr = 1'b1; hclr_hart = 2'd1;
    @(negedge sclk);
    mwre = 1'b0; hclr = 1'b0;
    count_busy(n);
    chk("hclr_write_len", n, 32'd32);
    rd(2'd1, 5'd6, 5'd5);
    chk("hclr_write_lost", rs1d, 32'd0);
    chk("hclr_h1r5", rs2d, 32'd0);

    srst_n = 1'b0;
    @(negedge sclk);
    srst_n = 1'b1;
    repeat (60) @(negedge sclk);
    chk("mid_sweep_busy", 32'(busy), 32'd1);
    srst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd1);
    chk("abort_rs1d", rs1d, 32'd0);
    @(negedge sclk);
    srst_n = 1'b1;
    count_busy(n);
    chk("restart_clear_len", n, 32'd128);
    rd(2'd0, 5'd1, 5'd2);
    chk("restart_h0r1", rs1d, 32'd0);
    chk("restart_h0r2", rs2d, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/t5_mgprf.md
T5_MGPRF -- requirements
Module: t5_mgprf

Interface
REQ-001 Parameter XLEN, default 32, data width of each register.
REQ-002 Parameter HW, default 2, hart-select width; NHART = 2**HW harts, 32 registers per hart.
REQ-003 Port sclk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port srst_n, input, 1, reset, asynchronous, active-low.
REQ-005 Port fhart, input, HW, hart whose registers are read this cycle.
REQ-006 Port rs1a / rs2a, input, 5 each, read register addresses.
REQ-007 Port rs1d / rs2d, output, XLEN each, registered read data.
REQ-008 Port mhart, input, HW, hart whose register is written.
REQ-009 Port rd0a, input, 5, write register address.
REQ-010 Port rd0d, input, XLEN, write data.
REQ-011 Port mwre, input, 1, write enable.
REQ-012 Port hclr, input, 1, single-cycle request to zero all registers of one hart.
REQ-013 Port hclr_hart, input, HW, hart to clear; sampled with hclr.
REQ-014 Port busy, output, 1, high while a clear sweep runs.

Function
REQ-015 Read latency: exactly 1 cycle; the address and fhart presented in cycle N give data on rs1d/rs2d in cycle N+1.
REQ-016 Address 0 of every hart reads as zero; mwre with rd0a=0 is discarded.
REQ-017 Bypass: mwre in cycle N with {mhart,rd0a} equal to {fhart,rsXa}, rd0a nonzero, gives rd0d on rsXd in N+1.
REQ-018 Both read ports are independent; identical rs1a/rs2a give identical data.
REQ-019 FSM states: CLR_ALL, RUN, CLR_HART.
REQ-020 CLR_ALL: a counter of width HW+5 walks 0..NHART*32-1, writing zero at one address per cycle; at the last address the FSM goes to RUN.
REQ-021 RUN: hclr=1 latches hclr_hart and goes to CLR_HART; a 5-bit counter walks 0..31 of that hart, writing zero; after address 31 the FSM returns to RUN.
REQ-022 busy=1 in CLR_ALL and CLR_HART; busy=0 from the cycle after the final clear write.
REQ-023 While busy=1:
  - mwre is ignored;
  - hclr is ignored;
  - rs1d/rs2d are forced to zero.
REQ-024 hclr and mwre in the same RUN cycle: the write is performed, then the target hart is cleared, so the written value is lost if the hart matches.
REQ-025 Latency totals:
  - full clear: NHART*32 cycles after srst_n deasserts, i.e. 128 at default;
  - hart clear: 32 cycles after the hclr cycle.

Reset
REQ-026 While srst_n=0: FSM=CLR_ALL, counter=0, busy=1, rs1d=rs2d=0.
REQ-027 Reset asserted mid-sweep aborts the sweep; the sweep restarts at address 0 after deassertion.
REQ-028 Storage arrays are not reset; all array contents are established by the clear sweep.

Structure
REQ-029 The shared package t5_pkg holds the XLEN default, the REGW=5 constant and the FSM state enumeration.
REQ-030 Storage uses two instances of the existing dpram sub-module, one per read port, with AW=HW+5 and DW=XLEN.
  - Each instance's write port is muxed between the user write and the clear-sweep write.
  - Bypass and zero-forcing logic sits after the instances.

Verification
REQ-031 Release reset -> busy high for exactly 128 cycles; reading any {hart,reg} afterwards returns 0.
REQ-032 Write hart1 reg5=0xDEADBEEF, then read fhart=1 rs1a=5 -> 0xDEADBEEF one cycle later; fhart=2 rs1a=5 -> 0.
REQ-033 Write reg0=0x12345678 -> rs1d and rs2d both read 0 at address 0.
REQ-034 Same-cycle write hart3 reg7=0xA5A5A5A5 and read fhart=3 rs2a=7 -> rs2d=0xA5A5A5A5 next cycle (bypass).
REQ-035 Fill harts 0 and 2 with nonzero values, then hclr with hclr_hart=2 ->
  - busy high for 32 cycles;
  - hart 2 reads 0;
  - hart 0 keeps its values;
  - a write during busy is not stored.
REQ-036 Assert srst_n low at sweep cycle 60 -> busy stays high; after release a full 128-cycle sweep completes.
